// File: rtl/matrix_coef_stream.sv
// ROWS x COLS coefficient store with a runtime write port and a handshaked
// streaming reader that emits every element in column- or row-major order.
module matrix_coef_stream #(
  parameter int DATA_W = 8,
  parameter int ROWS   = 3,
  parameter int COLS   = 3,
  parameter int ADDR_W = 4,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  input  logic              start,
  input  logic              mode,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_row,
  output logic [IDX_W-1:0]  out_col,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = ROWS * COLS;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  localparam logic [IDX_W-1:0]  ROW_MAX   = IDX_W'(ROWS - 1);
  localparam logic [IDX_W-1:0]  COL_MAX   = IDX_W'(COLS - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ROWS_A    = ADDR_W'(ROWS);

  logic [0:0]        state_reg;
  logic              mode_reg;
  logic [DATA_W-1:0] mem_reg [DEPTH];

  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic [IDX_W-1:0]  out_row_reg;
  logic [IDX_W-1:0]  out_col_reg;
  logic              out_last_reg;
  logic              done_reg;
  logic              wr_err_reg;

  logic              wr_in_range;
  logic              wr_accept;
  logic [DEPTH-1:0]  wr_hit;
  logic              handshake;

  logic [IDX_W-1:0]  ld_row_next;
  logic [IDX_W-1:0]  ld_col_next;
  logic              ld_last_next;
  logic [ADDR_W-1:0] rd_addr_next;
  logic [DATA_W-1:0] rd_data_next;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
  assign wr_accept   = wr_en && (state_reg == IDLE) && wr_in_range;
  assign handshake   = out_valid_reg && out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_hit
      assign wr_hit[gi] = wr_accept && (wr_addr == ADDR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_hit[i]) begin
          mem_reg[i] <= wr_data;
        end
      end
    end
  end

  // In IDLE the element to load is always (0,0); in STREAM it is the successor
  // of the element currently presented.
  always_comb begin
    ld_row_next = '0;
    ld_col_next = '0;
    if (state_reg == STREAM) begin
      if (!mode_reg) begin
        if (out_row_reg == ROW_MAX) begin
          ld_row_next = '0;
          ld_col_next = out_col_reg + IDX_W'(1);
        end else begin
          ld_row_next = out_row_reg + IDX_W'(1);
          ld_col_next = out_col_reg;
        end
      end else begin
        if (out_col_reg == COL_MAX) begin
          ld_col_next = '0;
          ld_row_next = out_row_reg + IDX_W'(1);
        end else begin
          ld_col_next = out_col_reg + IDX_W'(1);
          ld_row_next = out_row_reg;
        end
      end
    end
  end

  assign ld_last_next = (ld_row_next == ROW_MAX) && (ld_col_next == COL_MAX);
  assign rd_addr_next = ADDR_W'(ld_col_next) * ROWS_A + ADDR_W'(ld_row_next);

  // A write coinciding with start is forwarded so the stream sees the new value.
  always_comb begin
    rd_data_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr_next == ADDR_W'(i)) begin
        rd_data_next = mem_reg[i];
      end
    end
    if (wr_accept && (wr_addr == rd_addr_next)) begin
      rd_data_next = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      mode_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_row_reg   <= '0;
      out_col_reg   <= '0;
      out_last_reg  <= 1'b0;
      done_reg      <= 1'b0;
      wr_err_reg    <= 1'b0;
    end else begin
      done_reg   <= 1'b0;
      wr_err_reg <= wr_en && !wr_accept;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg     <= STREAM;
            mode_reg      <= mode;
            out_valid_reg <= 1'b1;
            out_data_reg  <= rd_data_next;
            out_row_reg   <= ld_row_next;
            out_col_reg   <= ld_col_next;
            out_last_reg  <= ld_last_next;
          end
        end
        STREAM: begin
          if (abort || (handshake && out_last_reg)) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_row_reg   <= '0;
            out_col_reg   <= '0;
            out_last_reg  <= 1'b0;
            done_reg      <= !abort;
          end else if (handshake) begin
            out_data_reg <= rd_data_next;
            out_row_reg  <= ld_row_next;
            out_col_reg  <= ld_col_next;
            out_last_reg <= ld_last_next;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_row   = out_row_reg;
  assign out_col   = out_col_reg;
  assign out_last  = out_last_reg;
  assign busy      = (state_reg == STREAM);
  assign done      = done_reg;
  assign wr_err    = wr_err_reg;

endmodule

// File: tb/tb_matrix_coef_stream.sv
// Randomised scoreboard bench for matrix_coef_stream: expected beats are queued
// at start, and a negedge monitor pops and compares them on every handshake.
module tb_matrix_coef_stream;

  localparam int DW = 8;
  localparam int R  = 3;
  localparam int C  = 3;
  localparam int AW = 4;
  localparam int IW = 4;
  localparam int N  = R * C;

  logic          clk = 1'b0;
  logic          rst, wr_en, start, mode, abort, out_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_err, out_valid, out_last, busy, done;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_row, out_col;

  matrix_coef_stream #(.DATA_W(DW), .ROWS(R), .COLS(C), .ADDR_W(AW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .start(start), .mode(mode), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [IW-1:0] r;
    logic [IW-1:0] c;
    logic          l;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] model_mem [N];
  int  errors = 0, checks = 0;
  int  hs_count = 0, wr_err_cnt = 0, exp_wr_err = 0;
  bit  last_seen = 0, expect_done = 0, mon_en = 0;
  bit  stall_prev = 0;
  beat_t prev_beat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      beat_t cur;
      beat_t e;
      cur = '{d: out_data, r: out_row, c: out_col, l: out_last};
      if (wr_err) wr_err_cnt++;
      if (expect_done) begin
        check("done_pulse", done, 1'b1);
        check("done_valid", out_valid, 1'b0);
        check("done_busy", busy, 1'b0);
        expect_done = 0;
      end else begin
        check("no_done", done, 1'b0);
      end
      check("busy_vs_valid", busy, out_valid);
      if (stall_prev) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_hold", cur, prev_beat);
      end
      if (out_valid && out_ready && !rst) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat_queue", 0, 1);
        end else begin
          e = exp_q.pop_front();
          check("beat", cur, e);
          $display("beat d=%0h r=%0d c=%0d last=%0d", out_data, out_row, out_col, out_last);
          if (e.l && !abort) begin
            last_seen   = 1;
            expect_done = 1;
          end
        end
      end
      stall_prev = out_valid && !out_ready && !abort && !rst;
      prev_beat  = cur;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    if (int'(a) < N) model_mem[a] = d;
    else exp_wr_err++;
    $display("write addr=%0d data=%0h", a, d);
    tick(1);
    wr_en = 0;
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1.
  task automatic run_stream(input bit md, input int rdy_mode, input int abort_n, input int rst_n,
                            input bit wr_busy, input bit wr_same,
                            input logic [AW-1:0] ws_addr, input logic [DW-1:0] ws_data);
    int  base;
    bit  fin;
    fin = 0;
    if (wr_same) begin
      wr_en = 1; wr_addr = ws_addr; wr_data = ws_data;
      if (int'(ws_addr) < N) model_mem[ws_addr] = ws_data;
      else exp_wr_err++;
    end
    start = 1; mode = md;
    if (!md) begin
      for (int c = 0; c < C; c++)
        for (int r = 0; r < R; r++)
          exp_q.push_back('{d: model_mem[c*R+r], r: IW'(r), c: IW'(c), l: (r == R-1 && c == C-1)});
    end else begin
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++)
          exp_q.push_back('{d: model_mem[c*R+r], r: IW'(r), c: IW'(c), l: (r == R-1 && c == C-1)});
    end
    $display("start mode=%0d ready_mode=%0d abort_at=%0d rst_at=%0d", md, rdy_mode, abort_n, rst_n);
    last_seen = 0;
    base = hs_count;
    tick(1);
    start = 0; wr_en = 0; mode = 1'($urandom);
    for (int k = 0; k < 200; k++) begin
      int beats;
      if (last_seen) begin fin = 1; break; end
      beats = hs_count - base;
      if (abort_n >= 0 && beats == abort_n) begin
        out_ready = 0; abort = 1;
        tick(1);
        abort = 0;
        check("abort_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_remaining", exp_q.size(), N - abort_n);
        exp_q.delete();
        fin = 1;
        break;
      end
      if (rst_n >= 0 && beats == rst_n) begin
        out_ready = 0; rst = 1;
        tick(1);
        rst = 0;
        check("rst_outputs", {out_valid, out_data, out_row, out_col, out_last, busy, done, wr_err}, '0);
        exp_q.delete();
        for (int i = 0; i < N; i++) model_mem[i] = '0;
        fin = 1;
        break;
      end
      if (wr_busy && k == 1) begin
        wr_en = 1; wr_addr = 2; wr_data = 8'hAA; exp_wr_err++;
      end else begin
        wr_en = 0;
      end
      case (rdy_mode)
        0:       out_ready = 1;
        1:       out_ready = (k % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      tick(1);
    end
    wr_en = 0; out_ready = 0;
    if (!fin) check("stream_timeout", 0, 1);
    else check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1; wr_en = 0; wr_addr = '0; wr_data = '0;
    start = 0; mode = 0; abort = 0; out_ready = 0;
    for (int i = 0; i < N; i++) model_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("reset_outputs", {out_valid, out_data, out_row, out_col, out_last, busy, done, wr_err}, '0);
    mon_en = 1;

    // Defaults after reset
    run_stream(0, 0, -1, -1, 0, 0, '0, '0);
    tick(2);
    // Column-major load and stream
    for (int i = 0; i < N; i++) do_write(AW'(i), DW'(8'h10 + i));
    tick(1);
    run_stream(0, 0, -1, -1, 0, 0, '0, '0);
    tick(2);
    // Row-major with toggling ready
    run_stream(1, 1, -1, -1, 0, 0, '0, '0);
    tick(2);
    // Write errors: out of range in IDLE, then a write while busy
    do_write(4'd9, 8'h55);
    tick(1);
    run_stream(0, 2, -1, -1, 1, 0, '0, '0);
    tick(2);
    run_stream(0, 0, -1, -1, 0, 0, '0, '0);
    tick(2);
    check("wr_err_count", wr_err_cnt, exp_wr_err);
    // Abort after 4 beats, then a fresh stream
    run_stream(0, 0, 4, -1, 0, 0, '0, '0);
    tick(2);
    run_stream(0, 0, -1, -1, 0, 0, '0, '0);
    // Back-to-back: start lands in the done cycle
    run_stream(1, 0, -1, -1, 0, 0, '0, '0);
    tick(2);
    // Write together with start
    run_stream(0, 0, -1, -1, 0, 1, 4'd0, 8'h77);
    tick(2);
    // Reset mid-stream, then the memory reads back as zero
    run_stream(0, 0, -1, 4, 0, 0, '0, '0);
    tick(2);
    run_stream(1, 0, -1, -1, 0, 0, '0, '0);
    tick(2);

    for (int it = 0; it < 20; it++) begin
      int nw;
      int ab;
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++) do_write(AW'($urandom_range(0, 11)), DW'($urandom));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N-1)) : -1;
      run_stream(1'($urandom), 2, ab, -1, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 10)), DW'($urandom));
      tick($urandom_range(0, 2));
    end
    tick(3);
    check("wr_err_count_final", wr_err_cnt, exp_wr_err);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_coef_stream.md
Name: matrix_coef_stream

Overview:
Parametrised ROWS x COLS coefficient store with a runtime write port and a handshaked streaming read engine. After a start pulse it emits every element in column-major or row-major order, with row and column tags and a last flag. It feeds the matrix multiply datapath in place of fixed-constant coefficient ROMs.

Parameters:
DATA_W, 8, element width in bits
ROWS, 3, matrix rows (>=1)
COLS, 3, matrix columns (>=1)
ADDR_W, 4, linear address width; 2^ADDR_W >= ROWS*COLS required
IDX_W, 4, width of row/col tags; 2^IDX_W >= max(ROWS,COLS) required

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  linear address; element (r,c) is at c*ROWS+r (column-major)
wr_data  in  DATA_W  write data
wr_err  out  1  one-cycle pulse: write dropped (busy or address out of range)
start  in  1  begin stream; sampled only in IDLE
mode  in  1  0 = column-major, 1 = row-major; latched with start
abort  in  1  cancel active stream
out_valid  out  1  out_data holds a valid element
out_ready  in  1  consumer accepts the element
out_data  out  DATA_W  element value
out_row  out  IDX_W  row index of out_data
out_col  out  IDX_W  column index of out_data
out_last  out  1  out_data is the final element of the stream
busy  out  1  stream in progress
done  out  1  one-cycle pulse after the final handshake

Behaviour:
- Reset (rst=1 at an edge): all ROWS*COLS entries cleared to 0; state IDLE. out_valid, out_data, out_row, out_col, out_last, busy, done and wr_err all 0. Reset mid-stream discards the stream; no done pulse.
- Storage: flop array of ROWS*COLS x DATA_W.
- Write: accepted when wr_en=1, state IDLE and wr_addr < ROWS*COLS. The entry updates at that edge and is readable by a start on the next cycle.
  - Write while busy, or to an out-of-range address: entry unchanged; wr_err=1 the next cycle.
  - wr_en with start in the same IDLE cycle: the write lands first, so the stream sees the new value.
- FSM states: IDLE, STREAM.
  - IDLE -> STREAM on start=1. mode is latched; row and col counters are set to 0.
  - STREAM -> IDLE on the final handshake, or on abort=1.
- Output register:
  - Cycle t start -> at t+1: out_valid=1, busy=1, element (0,0).
  - Handshake = out_valid & out_ready. On each handshake the next element loads at the same edge, giving 1 element/cycle throughput with out_ready held high.
  - While out_valid=1 and out_ready=0, all out_* signals hold stable.
- Order:
  - mode=0: row increments fastest; at row==ROWS-1 it wraps to 0 and col increments.
  - mode=1: col increments fastest; at col==COLS-1 it wraps to 0 and row increments.
- out_last=1 exactly when (row,col) == (ROWS-1,COLS-1).
- Final handshake: the next cycle has out_valid=0, busy=0, done=1 for one cycle. A start in that done cycle is accepted.
- ROWS=COLS=1: a single element with out_last=1 on the first beat.
- abort in STREAM: the next cycle has out_valid=0, busy=0 and no done. A handshake coinciding with abort is consumed by the consumer, but the stream still terminates.
- abort and start together in IDLE: start wins; abort is ignored in IDLE.
- start while busy: ignored.
- out_ready while out_valid=0: no effect.

Test Plan:
1. Reset and defaults: assert rst for 2 cycles, then start with mode=0 and out_ready=1 -> 9 beats of data 0x00 with tags (0,0),(1,0),(2,0),(0,1)…(2,2); out_last on beat 9; done 1 cycle later.
2. Load and stream, column-major: write addr 0..8 = 0x10..0x18, start mode=0, out_ready=1 -> out_valid from cycle t+1; data 0x10..0x18 on consecutive cycles; beat 4 tagged row=0, col=1, data 0x13.
3. Row-major with backpressure: same load, mode=1, out_ready toggling 1,0,1,0… -> sequence 0x10,0x13,0x16,0x11,0x14,0x17,0x12,0x15,0x18; data and tags stable during every ready=0 cycle; done only after the 9th handshake.
4. Write errors: wr_en to addr 9 in IDLE -> wr_err pulse, readback unchanged. wr_en addr 2 = 0xAA while busy -> wr_err pulse; a later stream shows 0x12 at (2,0).
5. Abort: start mode=0, accept 4 beats, assert abort -> out_valid=0 and busy=0 the next cycle, done never pulses. A new start then streams from (0,0).
6. Back-to-back and reset mid-stream: start in the done cycle -> new stream begins the next cycle. rst asserted at beat 5 -> outputs 0 the next cycle, memory reads 0x00 on the following stream.
